// File: rtl/sh7034_pkg.sv
// Shared encodings for the SH7034 multiplier command sequencer: op codes,
// MACH/MACL select codes, sequencer state type and small decode helpers.
package sh7034_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_N,
    ST_FETCH_M,
    ST_ISSUE,
    ST_WAIT,
    ST_READ
  } state_e;

  localparam logic [3:0] OP_LDS_R   = 4'b0000;
  localparam logic [3:0] OP_LDS_M   = 4'b1000;
  localparam logic [3:0] OP_MUL_L   = 4'b0001;
  localparam logic [3:0] OP_DMULU_L = 4'b0010;
  localparam logic [3:0] OP_DMULS_L = 4'b0011;
  localparam logic [3:0] OP_MULU_W  = 4'b0110;
  localparam logic [3:0] OP_MULS_W  = 4'b0111;
  localparam logic [3:0] OP_MAC_L   = 4'b1001;
  localparam logic [3:0] OP_MAC_W   = 4'b1011;
  localparam logic [3:0] OP_CLRMAC  = 4'b1111;
  localparam logic [3:0] OP_STS     = 4'b0100;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_MACL = 2'b01;
  localparam logic [1:0] SEL_MACH = 2'b10;
  localparam logic [1:0] SEL_BOTH = 2'b11;

  function automatic logic sel_valid(input logic [1:0] sel);
    return (sel == SEL_MACL) || (sel == SEL_MACH);
  endfunction

  function automatic logic is_mac(input logic [3:0] op);
    return (op == OP_MAC_L) || (op == OP_MAC_W);
  endfunction

  function automatic logic is_mul_long(input logic [3:0] op);
    return (op == OP_MUL_L) || (op == OP_DMULU_L) || (op == OP_DMULS_L);
  endfunction

  function automatic logic [31:0] post_inc(input logic [3:0] op);
    return (op == OP_MAC_W) ? 32'd2 : 32'd4;
  endfunction

endpackage

// File: rtl/mac_seq.sv
// Multiplier command sequencer: operand fetch, MACH/MACL writes, STS read-back.
// Define MAC_SEQ_INTERLOCK_EN to hold CMD_READY low for two cycles after the last write.
module mac_seq
  import sh7034_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [3:0]  CMD_OP,
  input  logic [1:0]  CMD_SEL,
  input  logic        CMD_S,
  input  logic [31:0] CMD_RM,
  input  logic [31:0] CMD_RN,
  output logic [27:0] MEM_A,
  output logic        MEM_REQ,
  input  logic        MEM_BUSY,
  input  logic [31:0] MEM_DI,
  output logic [1:0]  MAC_SEL,
  output logic [3:0]  MAC_OP,
  output logic        MAC_S,
  output logic        MAC_WE,
  output logic [27:0] MAC_A,
  output logic [31:0] MAC_DO,
  input  logic [31:0] MAC_DI,
  output logic [31:0] RES_DATA,
  output logic        RES_VALID,
  output logic [31:0] RM_NEXT,
  output logic [31:0] RN_NEXT,
  output logic        RM_WE,
  output logic        RN_WE
);

  logic unused_ce_f;
  assign unused_ce_f = CE_F;

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  sel_q, sel_d;
  logic        s_q, s_d;
  logic [31:0] rm_q, rm_d, rn_q, rn_d;

  logic        ready_q, ready_d;
  logic        mem_req_q, mem_req_d;
  logic [27:0] mem_a_q, mem_a_d;
  logic [1:0]  mac_sel_q, mac_sel_d;
  logic [3:0]  mac_op_q, mac_op_d;
  logic        mac_s_q, mac_s_d;
  logic        mac_we_q, mac_we_d;
  logic [27:0] mac_a_q, mac_a_d;
  logic [31:0] mac_do_q, mac_do_d;
  logic        fwe_q, fwe_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] rm_next_q, rm_next_d, rn_next_q, rn_next_d;
  logic        rm_we_q, rm_we_d, rn_we_q, rn_we_d;
  logic        done;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    sel_d       = sel_q;
    s_d         = s_q;
    rm_d        = rm_q;
    rn_d        = rn_q;
    res_data_d  = res_data_q;
    res_valid_d = 1'b0;
    rm_next_d   = rm_next_q;
    rn_next_d   = rn_next_q;
    rm_we_d     = 1'b0;
    rn_we_d     = 1'b0;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID && ready_q) begin
          op_d    = CMD_OP;
          sel_d   = CMD_SEL;
          s_d     = CMD_S;
          rm_d    = CMD_RM;
          rn_d    = CMD_RN;
          phase_d = 1'b1;
          case (CMD_OP)
            OP_MUL_L, OP_DMULU_L, OP_DMULS_L: begin
              state_d = ST_ISSUE;
              phase_d = 1'b0;
            end
            OP_MULU_W, OP_MULS_W, OP_CLRMAC: state_d = ST_ISSUE;
            OP_LDS_R: if (sel_valid(CMD_SEL)) state_d = ST_ISSUE;
            OP_LDS_M:           state_d = ST_FETCH_M;
            OP_MAC_L, OP_MAC_W: state_d = ST_FETCH_N;
            OP_STS:             state_d = ST_READ;
            default:            state_d = ST_IDLE;
          endcase
        end
      end
      ST_ISSUE: begin
        if (!phase_q) phase_d = 1'b1;
        else          done    = 1'b1;
      end
      ST_FETCH_N: begin
        if (!MEM_BUSY) begin
          rn_next_d = rn_q + post_inc(op_q);
          rn_we_d   = 1'b1;
          state_d   = ST_FETCH_M;
        end
      end
      ST_FETCH_M: begin
        if (!MEM_BUSY) begin
          rm_next_d = rm_q + post_inc(op_q);
          rm_we_d   = 1'b1;
          done      = 1'b1;
        end
      end
      ST_READ: begin
        res_valid_d = 1'b1;
        res_data_d  = sel_valid(sel_q) ? MAC_DI : '0;
        state_d     = ST_IDLE;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (done) begin
`ifdef MAC_SEQ_INTERLOCK_EN
      if (state_q == ST_ISSUE || fwe_q) begin
        state_d = ST_WAIT;
        cnt_d   = 2'd2;
      end else begin
        state_d = ST_IDLE;
      end
`else
      state_d = ST_IDLE;
`endif
    end

    // Outputs are decoded from the next state so they appear registered.
    ready_d   = (state_d == ST_IDLE) && (cnt_d == 2'd0);
    mem_req_d = 1'b0;
    mem_a_d   = '0;
    mac_sel_d = SEL_NONE;
    mac_op_d  = '0;
    mac_s_d   = 1'b0;
    mac_we_d  = 1'b0;
    mac_a_d   = '0;
    mac_do_d  = '0;
    fwe_d     = 1'b0;

    case (state_d)
      ST_ISSUE: begin
        mac_we_d = 1'b1;
        mac_op_d = op_d;
        if (is_mul_long(op_d)) begin
          mac_sel_d = phase_d ? SEL_MACH : SEL_MACL;
          mac_do_d  = phase_d ? rm_d : rn_d;
        end else if (op_d == OP_MULU_W || op_d == OP_MULS_W) begin
          mac_sel_d = SEL_MACH;
          mac_do_d  = {rm_d[15:0], rn_d[15:0]};
        end else if (op_d == OP_CLRMAC) begin
          mac_sel_d = SEL_BOTH;
        end else begin
          mac_sel_d = sel_d;
          mac_do_d  = rm_d;
        end
      end
      ST_FETCH_N: begin
        mem_req_d = 1'b1;
        mem_a_d   = rn_d[27:0];
        mac_a_d   = rn_d[27:0];
        mac_sel_d = SEL_MACL;
        mac_op_d  = op_d;
        mac_s_d   = s_d;
        fwe_d     = 1'b1;
      end
      ST_FETCH_M: begin
        mem_req_d = 1'b1;
        mem_a_d   = rm_d[27:0];
        mac_a_d   = rm_d[27:0];
        mac_sel_d = is_mac(op_d) ? SEL_MACH : sel_d;
        mac_op_d  = op_d;
        mac_s_d   = s_d & is_mac(op_d);
        fwe_d     = is_mac(op_d) || sel_valid(sel_d);
      end
      ST_READ: begin
        mac_sel_d = sel_d;
        mac_op_d  = op_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
      op_q        <= '0;
      sel_q       <= '0;
      s_q         <= 1'b0;
      rm_q        <= '0;
      rn_q        <= '0;
      ready_q     <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_a_q     <= '0;
      mac_sel_q   <= '0;
      mac_op_q    <= '0;
      mac_s_q     <= 1'b0;
      mac_we_q    <= 1'b0;
      mac_a_q     <= '0;
      mac_do_q    <= '0;
      fwe_q       <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      rm_next_q   <= '0;
      rn_next_q   <= '0;
      rm_we_q     <= 1'b0;
      rn_we_q     <= 1'b0;
    end else if (CE_R) begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      sel_q       <= sel_d;
      s_q         <= s_d;
      rm_q        <= rm_d;
      rn_q        <= rn_d;
      ready_q     <= ready_d;
      mem_req_q   <= mem_req_d;
      mem_a_q     <= mem_a_d;
      mac_sel_q   <= mac_sel_d;
      mac_op_q    <= mac_op_d;
      mac_s_q     <= mac_s_d;
      mac_we_q    <= mac_we_d;
      mac_a_q     <= mac_a_d;
      mac_do_q    <= mac_do_d;
      fwe_q       <= fwe_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      rm_next_q   <= rm_next_d;
      rn_next_q   <= rn_next_d;
      rm_we_q     <= rm_we_d;
      rn_we_q     <= rn_we_d;
    end
  end

  // A fetch write strobes in the cycle the read completes, forwarding MEM_DI directly.
  assign MAC_WE    = mac_we_q | (fwe_q & mem_req_q & ~MEM_BUSY & CE_R & RST_N);
  assign MAC_DO    = mem_req_q ? MEM_DI : mac_do_q;
  assign CMD_READY = ready_q;
  assign MEM_REQ   = mem_req_q;
  assign MEM_A     = mem_a_q;
  assign MAC_SEL   = mac_sel_q;
  assign MAC_OP    = mac_op_q;
  assign MAC_S     = mac_s_q;
  assign MAC_A     = mac_a_q;
  assign RES_DATA  = res_data_q;
  assign RES_VALID = res_valid_q;
  assign RM_NEXT   = rm_next_q;
  assign RN_NEXT   = rn_next_q;
  assign RM_WE     = rm_we_q;
  assign RN_WE     = rn_we_q;

endmodule
